// File: rtl/show_if.sv
// Interface bundle for the show block: operator inputs and display/status outputs.
// The master side drives controls; the slave side (the show core) returns status.
interface show_if;
    logic [1:0]  key;
    logic [1:0]  sw;
    logic [3:0]  ji;
    logic [15:0] data;
    logic [6:0]  light;
    logic [1:0]  com;
    logic [3:0]  led;
    logic [3:0]  index;
    logic [25:0] tim;
    logic [7:0]  num;

    modport master (
        output key, sw, ji, data,
        input  light, com, led, index, tim, num
    );

    modport slave (
        input  key, sw, ji, data,
        output light, com, led, index, tim, num
    );
endinterface

// File: rtl/show.sv
// Circular 4-bit window scanner over a 16-bit word with pattern count and 2-digit display.
// Optional key debounce is compiled in with macro KEY_DEBOUNCE_EN.
module show #(
    parameter int unsigned TICK_MAX        = 50000000,
    parameter int unsigned SCAN_BIT        = 15,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic   clk,
    input logic   rst,
    show_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_SEARCH = 2'b11
    } mode_t;

    if (TICK_MAX < 2 || TICK_MAX > (1 << 26)) begin : g_bad_tick
        $error("show: TICK_MAX out of range");
    end
    if (SCAN_BIT > 25) begin : g_bad_scan
        $error("show: SCAN_BIT out of range");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("show: DEBOUNCE_CYCLES must be at least 1");
    end

    mode_t       mode;
    logic [25:0] tim_q;
    logic        tick;
    logic [3:0]  index_q;
    logic [3:0]  index_d;
    logic [3:0]  led_q;
    logic [7:0]  num_q;
    logic [3:0]  cur_win;
    logic [4:0]  match_cnt;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  key_level;
    logic [1:0]  key_prev;
    logic [1:0]  press;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [3:0]  digit;

    function automatic logic [3:0] window_at(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] w;
        w = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w[k] = d[4'(p + 4'(k))];
        end
        return w;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign mode = mode_t'(bus.sw);

    // Prescaler and step tick
    assign tick = (tim_q == 26'(TICK_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tim_q <= '0;
        end else if (tick) begin
            tim_q <= '0;
        end else begin
            tim_q <= tim_q + 26'd1;
        end
    end

    // Key synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.key;
            sync2 <= sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      stable;
    logic [DB_W-1:0] db_cnt [2];

    // A key level is accepted only once it has differed from the accepted level for the full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable    <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign key_level = stable;
`else
    assign key_level = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev <= '0;
        end else begin
            key_prev <= key_level;
        end
    end

    assign press = key_level & ~key_prev;

    // Window and pattern matching
    assign cur_win = window_at(bus.data, index_q);

    always_comb begin
        match_cnt = '0;
        for (int unsigned p = 0; p < 16; p++) begin
            if (window_at(bus.data, 4'(p)) == bus.ji) begin
                match_cnt = match_cnt + 5'd1;
            end
        end
    end

    // Index controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    always_comb begin
        index_d = index_q;
        unique case (mode)
            MODE_HOLD: begin
                index_d = index_q;
            end
            MODE_AUTO: begin
                if (tick) begin
                    index_d = index_q + 4'd1;
                end
            end
            MODE_MANUAL: begin
                case (press)
                    2'b01:   index_d = index_q + 4'd1;
                    2'b10:   index_d = index_q - 4'd1;
                    default: index_d = index_q;
                endcase
            end
            MODE_SEARCH: begin
                if (tick && (cur_win != bus.ji)) begin
                    index_d = index_q + 4'd1;
                end
            end
        endcase
    end

    // Registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
            num_q <= '0;
        end else begin
            led_q <= cur_win;
            num_q <= {3'b000, match_cnt};
        end
    end

    // num never exceeds 16, so the decimal split reduces to one compare
    always_comb begin
        tens = 4'd0;
        ones = num_q[3:0];
        if (num_q >= 8'd10) begin
            tens = 4'd1;
            ones = 4'(num_q - 8'd10);
        end
    end

    assign digit     = tim_q[SCAN_BIT] ? tens : ones;
    assign bus.com   = tim_q[SCAN_BIT] ? 2'b01 : 2'b10;
    assign bus.light = seg_code(digit);
    assign bus.led   = led_q;
    assign bus.index = index_q;
    assign bus.tim   = tim_q;
    assign bus.num   = num_q;

endmodule

// File: tb/tb_show.sv
// Self-checking bench for show: vector table, directed mode sequences and a randomized run
// compared against a behavioural model of the window/count/index rules.
module tb_show;
    localparam int TICK = 4;
    localparam int SB   = 1;
    localparam int DB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    show_if bus();

    show #(.TICK_MAX(TICK), .SCAN_BIT(SB), .DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int         m_tim;
    int         m_index;
    logic [3:0] m_led;
    int         m_num;
    logic [1:0] kh [3];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic [15:0] data;
        logic [3:0]  ji;
        int          num;
        logic [3:0]  led;
        logic [6:0]  tens_seg;
        logic [6:0]  ones_seg;
    } vec_t;

    vec_t vt [12];

    function automatic logic [3:0] win(input logic [15:0] d, input int p);
        logic [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = d[(p + k) % 16];
        return w;
    endfunction

    function automatic int count_matches(input logic [15:0] d, input logic [3:0] j);
        int c = 0;
        for (int p = 0; p < 16; p++) if (win(d, p) == j) c++;
        return c;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tim   = 0;
        m_index = 0;
        m_led   = '0;
        m_num   = 0;
        for (int i = 0; i < 3; i++) kh[i] = '0;
    endtask

    // One rising edge of the reference behaviour, using the inputs applied before the edge.
    task automatic model_edge();
        logic [1:0] press;
        bit tick;
        tick  = (m_tim == TICK - 1);
`ifdef KEY_DEBOUNCE_EN
        press = '0;
`else
        press = kh[1] & ~kh[2];
`endif
        m_led = win(bus.data, m_index);
        m_num = count_matches(bus.data, bus.ji);
        case (bus.sw)
            2'b01: if (tick) m_index = (m_index + 1) % 16;
            2'b10: begin
                if (press == 2'b01) m_index = (m_index + 1) % 16;
                else if (press == 2'b10) m_index = (m_index + 15) % 16;
            end
            2'b11: if (tick && win(bus.data, m_index) != bus.ji) m_index = (m_index + 1) % 16;
            default: ;
        endcase
        m_tim = (m_tim + 1) % TICK;
        kh[2] = kh[1];
        kh[1] = kh[0];
        kh[0] = bus.key;
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_com;
        logic [6:0] exp_light;
        exp_com   = ((m_tim >> SB) & 1) ? 2'b01 : 2'b10;
        exp_light = (exp_com == 2'b10) ? seg_tab[m_num % 10] : seg_tab[m_num / 10];
        chk({tag, ".tim"},   bus.tim,   m_tim);
        chk({tag, ".index"}, bus.index, m_index);
        chk({tag, ".led"},   bus.led,   m_led);
        chk({tag, ".num"},   bus.num,   m_num);
        chk({tag, ".com"},   bus.com,   exp_com);
        chk({tag, ".light"}, bus.light, exp_light);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        chk({tag, ".com_rst"},   bus.com,   2'b10);
        chk({tag, ".light_rst"}, bus.light, 7'b1000000);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic key_pulse(input logic [1:0] k);
        bus.key = k;
        step("man");
        bus.key = '0;
        repeat (4) step("man");
    endtask

    initial begin
        int man_exp [4];
        int prev_index;
        logic [1:0] exp_com;

        vt[0]  = '{16'h3C3C, 4'hF, 2,  4'hC, 7'b1000000, 7'b0100100};
        vt[1]  = '{16'hFFFF, 4'hF, 16, 4'hF, 7'b1111001, 7'b0000010};
        vt[2]  = '{16'h0000, 4'h0, 16, 4'h0, 7'b1111001, 7'b0000010};
        vt[3]  = '{16'h0000, 4'hF, 0,  4'h0, 7'b1000000, 7'b1000000};
        vt[4]  = '{16'h0001, 4'h1, 1,  4'h1, 7'b1000000, 7'b1111001};
        vt[5]  = '{16'h0001, 4'h8, 1,  4'h1, 7'b1000000, 7'b1111001};
        vt[6]  = '{16'hAAAA, 4'h5, 8,  4'hA, 7'b1000000, 7'b0000000};
        vt[7]  = '{16'hAAAA, 4'hA, 8,  4'hA, 7'b1000000, 7'b0000000};
        vt[8]  = '{16'h8001, 4'h3, 1,  4'h1, 7'b1000000, 7'b1111001};
        vt[9]  = '{16'hF0F0, 4'h0, 2,  4'h0, 7'b1000000, 7'b0100100};
        vt[10] = '{16'h7FFF, 4'hF, 12, 4'hF, 7'b1111001, 7'b0100100};
        vt[11] = '{16'h0000, 4'h5, 0,  4'h0, 7'b1000000, 7'b1000000};

        bus.key  = '0;
        bus.sw   = 2'b00;
        bus.ji   = 4'hF;
        bus.data = 16'h3C3C;
        model_reset();

        // Hold mode: pattern counts and display digits
        apply_reset("rst0");
        for (int i = 0; i < 12; i++) begin
            bus.data = vt[i].data;
            bus.ji   = vt[i].ji;
            step("tbl");
            exp_com = ((m_tim >> SB) & 1) ? 2'b01 : 2'b10;
            chk($sformatf("tbl%0d.num", i),   bus.num,   vt[i].num);
            chk($sformatf("tbl%0d.led", i),   bus.led,   vt[i].led);
            chk($sformatf("tbl%0d.index", i), bus.index, 0);
            chk($sformatf("tbl%0d.light", i), bus.light,
                (exp_com == 2'b10) ? vt[i].ones_seg : vt[i].tens_seg);
        end

        // Auto mode with wrap
        apply_reset("rst_auto");
        bus.sw   = 2'b01;
        bus.data = 16'h3C3C;
        bus.ji   = 4'hF;
        prev_index = 0;
        for (int i = 0; i < 72; i++) begin
            step("auto");
            if (m_index == 2 && prev_index == 2) chk("auto.led_at_2", bus.led, 4'hF);
            if (prev_index == 15 && m_index != 15) chk("auto.wrap", bus.index, 0);
            prev_index = m_index;
        end

        // Manual mode key presses
`ifdef KEY_DEBOUNCE_EN
        man_exp = '{0, 0, 0, 0};
`else
        man_exp = '{1, 0, 15, 15};
`endif
        apply_reset("rst_man");
        bus.sw = 2'b10;
        key_pulse(2'b01);
        chk("man.up", bus.index, man_exp[0]);
        key_pulse(2'b10);
        chk("man.down", bus.index, man_exp[1]);
        key_pulse(2'b10);
        chk("man.down_wrap", bus.index, man_exp[2]);
        key_pulse(2'b11);
        chk("man.both", bus.index, man_exp[3]);

        // Search mode: stops on match, keeps stepping when there is none
        apply_reset("rst_srch");
        bus.sw   = 2'b11;
        bus.data = 16'h3C3C;
        bus.ji   = 4'hF;
        repeat (24) step("srch");
        chk("srch.stop", bus.index, 2);
        bus.ji = 4'h5;
        repeat (16) step("srch");
        chk("srch.nomatch", bus.index, 6);
        chk("srch.num0", bus.num, 0);

        // Full count, then reset mid-operation
        apply_reset("rst_full");
        bus.sw   = 2'b01;
        bus.data = 16'hFFFF;
        bus.ji   = 4'hF;
        repeat (3) step("full");
        chk("full.num", bus.num, 16);
        exp_com = ((m_tim >> SB) & 1) ? 2'b01 : 2'b10;
        chk("full.light", bus.light, (exp_com == 2'b10) ? 7'b0000010 : 7'b1111001);
        step("full");
        exp_com = ((m_tim >> SB) & 1) ? 2'b01 : 2'b10;
        chk("full.light2", bus.light, (exp_com == 2'b10) ? 7'b0000010 : 7'b1111001);
        apply_reset("rst_mid");
        chk("rst_mid.tim", bus.tim, 0);
        chk("rst_mid.num", bus.num, 0);

        // Randomized run against the model
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0) bus.sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                bus.data = 16'($urandom);
                if ($urandom_range(0, 1) == 0) bus.ji = win(bus.data, $urandom_range(0, 15));
                else bus.ji = 4'($urandom);
            end
`ifdef KEY_DEBOUNCE_EN
            bus.key = '0;
`else
            bus.key = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
`endif
            if ($urandom_range(0, 149) == 0) apply_reset("rnd_rst");
            else step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/show.md
SHOW -- requirements
Module: show

Interface
REQ-001 Parameter TICK_MAX, default 50000000, step-tick period in clk cycles (2..2^26).
REQ-002 Parameter SCAN_BIT, default 15, tim bit driving digit multiplex (0..25).
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, key stable time when debounce is compiled in.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 key  input  2  push buttons; key[0] step up, key[1] step down (manual mode).
REQ-007 sw  input  2  mode: 00 hold, 01 auto, 10 manual, 11 search.
REQ-008 ji  input  4  4-bit reference pattern.
REQ-009 data  input  16  data word scanned circularly.
REQ-010 light  output  7  active-low segments {g,f,e,d,c,b,a} of selected digit.
REQ-011 com  output  2  active-low digit select; 2'b10 ones digit, 2'b01 tens digit.
REQ-012 led  output  4  registered current window.
REQ-013 index  output  4  current window start position.
REQ-014 tim  output  26  free-running prescaler count.
REQ-015 num  output  8  registered count of matching positions, binary, 0..16.

Function
REQ-016 tim SHALL count 0..TICK_MAX-1 and wrap to 0; tick SHALL be a 1-cycle pulse on the cycle tim==TICK_MAX-1.
REQ-017 Window SHALL be w[k]=data[(index+k) mod 16], k=0..3; wrap past bit 15 to bit 0.
REQ-018 led SHALL register w every cycle (1-cycle latency from index/data change).
REQ-019 num SHALL register, every cycle, the number of positions p in 0..15 whose window equals ji.
REQ-020 key SHALL pass a 2-flop synchronizer; a press is a 0->1 edge of the synchronized signal; a 1-cycle-wide pulse SHALL be captured.
REQ-021 Mode 00: index SHALL hold.
REQ-022 Mode 01: index SHALL increment mod 16 on every tick.
REQ-023 Mode 10: key[0] press SHALL increment index mod 16, key[1] press SHALL decrement mod 16; simultaneous presses SHALL leave index unchanged; tick ignored.
REQ-024 Mode 11: on tick, index SHALL increment mod 16 only while current window != ji; when equal it SHALL stop; if num==0 it SHALL keep stepping.
REQ-025 Key presses outside mode 10 SHALL be ignored; mode changes take effect next cycle without resetting index or tim.
REQ-026 Display digits: tens=num/10, ones=num%10; com SHALL be 2'b10 when tim[SCAN_BIT]==0, else 2'b01; light SHALL carry the selected digit.
REQ-027 Segment codes (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-028 While rst==0: tim=0, index=0, led=0, num=0, synchronizer flops=0, com=2'b10, light=1000000.
REQ-029 Reset asserted mid-operation SHALL clear all state immediately; operation resumes on first clk edge after release, tim starting from 0.

Configuration
REQ-030 Macro KEY_DEBOUNCE_EN defined: each synchronized key SHALL be accepted only after stable DEBOUNCE_CYCLES cycles; shorter pulses ignored.
REQ-031 Macro KEY_DEBOUNCE_EN undefined: no debounce; synchronized edges used directly (REQ-020).

Verification
REQ-032 rst=0 then 1, sw=00, data=16'h3C3C, ji=4'hF -> index=0, num=2 (positions 2,10), com=10, light=0100100.
REQ-033 TICK_MAX=4, sw=01 -> index increments every 4 cycles, 15->0 wrap; led=4'hF when index=2.
REQ-034 sw=10, key=2'b01 one cycle -> index +1; key=2'b10 -> index -1 (0->15); key=2'b11 -> unchanged; with KEY_DEBOUNCE_EN, 1-cycle pulse -> unchanged.
REQ-035 sw=11, TICK_MAX=4, data=3C3C, ji=F, from index=0 -> stops at 2; ji=4'h5 (num=0) -> keeps stepping.
REQ-036 data=16'hFFFF, ji=F -> num=16, tens=1 (1111001), ones=6 (0000010); rst pulsed mid-count -> all outputs return to REQ-028 values.
